// File: rtl/lbp_window_sched.sv
// Raster-scan fetch scheduler for 3x3 LBP windows with column reuse between slides.
// Optional macro LBP_CODE_EN adds a registered 8-bit LBP code output (win_code).
module lbp_window_sched #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int AW    = 14,
    parameter int DW    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [AW-1:0]     gray_addr,
    input  logic [DW-1:0]     gray_data,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [AW-1:0]     win_addr,
    output logic [9*DW-1:0]   win_pix,
`ifdef LBP_CODE_EN
    output logic [7:0]        win_code,
`endif
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_SLIDE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int          LOG_W    = $clog2(IMG_W);
    localparam logic [AW-1:0] LAST_COL = AW'(IMG_W - 2);
    localparam logic [AW-1:0] LAST_ROW = AW'(IMG_H - 2);

    logic [2:0]      state;
    logic [AW-1:0]   row;
    logic [AW-1:0]   col;
    logic [1:0]      r_idx;
    logic [1:0]      c_idx;
    logic            pend_valid;
    logic [3:0]      pend_slot;
    logic [9*DW-1:0] pix_nxt;
    logic            issuing;
    logic            accept;
    logic            row_end;
    logic            last_win;

    // Handshake: a window transfers on any edge where win_valid and win_ready
    // are both high; win_valid then stays low until the next window is complete.
    assign issuing   = (state == S_FILL) || (state == S_SLIDE);
    assign gray_req  = issuing && gray_ready;
    assign win_valid = (state == S_HOLD);
    assign accept    = win_valid && win_ready;
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign row_end   = (col == LAST_COL);
    assign last_win  = row_end && (row == LAST_ROW);

    // r_idx selects dy (0..2 -> -1..+1), c_idx selects dx; win_addr is the centre.
    assign gray_addr = issuing
        ? (win_addr - AW'(IMG_W) - AW'(1) + (AW'(r_idx) << LOG_W) + AW'(c_idx))
        : '0;

    always_comb begin
        pix_nxt = win_pix;
        if (accept && !row_end) begin
            for (int r = 0; r < 3; r++) begin
                pix_nxt[(3*r)*DW +: DW]   = win_pix[(3*r+1)*DW +: DW];
                pix_nxt[(3*r+1)*DW +: DW] = win_pix[(3*r+2)*DW +: DW];
            end
        end
        if (pend_valid) begin
            pix_nxt[int'(pend_slot)*DW +: DW] = gray_data;
        end
    end

`ifdef LBP_CODE_EN
    function automatic logic [7:0] lbp_code(input logic [9*DW-1:0] p);
        logic [7:0] c;
        int         k;
        c = '0;
        for (int j = 0; j < 8; j++) begin
            k    = (j < 4) ? j : j + 1;
            c[j] = (p[k*DW +: DW] >= p[4*DW +: DW]);
        end
        return c;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) win_code <= '0;
        else       win_code <= lbp_code(pix_nxt);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            row        <= '0;
            col        <= '0;
            r_idx      <= '0;
            c_idx      <= '0;
            pend_valid <= 1'b0;
            pend_slot  <= '0;
            win_addr   <= '0;
            win_pix    <= '0;
        end else begin
            pend_valid <= gray_req;
            pend_slot  <= 4'(r_idx) * 4'd3 + 4'(c_idx);
            win_pix    <= pix_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FILL;
                        row      <= AW'(1);
                        col      <= AW'(1);
                        win_addr <= AW'(IMG_W + 1);
                        r_idx    <= '0;
                        c_idx    <= '0;
                    end
                end
                S_FILL, S_SLIDE: begin
                    if (gray_req) begin
                        if (r_idx == 2'd2) begin
                            r_idx <= '0;
                            if (state == S_FILL && c_idx != 2'd2) c_idx <= c_idx + 2'd1;
                            else                                  state <= S_DRAIN;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end
                S_DRAIN: state <= S_HOLD;
                S_HOLD: begin
                    if (win_ready) begin
                        if (last_win) begin
                            state <= S_DONE;
                        end else if (row_end) begin
                            // From (r, W-2) to (r+1, 1) is +3 in row-major order.
                            state    <= S_FILL;
                            row      <= row + AW'(1);
                            col      <= AW'(1);
                            win_addr <= win_addr + AW'(3);
                            r_idx    <= '0;
                            c_idx    <= '0;
                        end else begin
                            state    <= S_SLIDE;
                            col      <= col + AW'(1);
                            win_addr <= win_addr + AW'(1);
                            r_idx    <= '0;
                            c_idx    <= 2'd2;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_window_sched.sv
// Bench for lbp_window_sched: directed frame scan with read-address and window scoreboards.
module tb_lbp_window_sched;
    localparam int IMG_W     = 128;
    localparam int IMG_H     = 128;
    localparam int AW        = 14;
    localparam int DW        = 8;
    localparam int PW        = 9 * DW;
    localparam int NWIN      = (IMG_W - 2) * (IMG_H - 2);
    localparam int LAST_ADDR = (IMG_H - 2) * IMG_W + IMG_W - 2;

    logic          clk;
    logic          reset;
    logic          start;
    logic          gray_ready;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic [DW-1:0] gray_data;
    logic          win_valid;
    logic          win_ready;
    logic [AW-1:0] win_addr;
    logic [PW-1:0] win_pix;
`ifdef LBP_CODE_EN
    logic [7:0]    win_code;
`endif
    logic          busy;
    logic          done;

    lbp_window_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .gray_ready(gray_ready),
        .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
        .win_valid(win_valid), .win_ready(win_ready), .win_addr(win_addr),
        .win_pix(win_pix),
`ifdef LBP_CODE_EN
        .win_code(win_code),
`endif
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp   = 0;
    int n_fail  = 0;
    int win_cnt = 0;
    logic mon_en   = 1'b0;
    logic chk_done = 1'b0;
    logic [AW-1:0]    exp_rd_q[$];
    logic [AW+PW-1:0] exp_win_q[$];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix_of(input int a);
`ifdef LBP_CODE_EN
        return 8'h55;
`else
        return DW'(a);
`endif
    endfunction

    function automatic logic [PW-1:0] exp_window(input int a);
        logic [PW-1:0] w;
        for (int k = 0; k < 9; k++) begin
            w[k*DW +: DW] = pix_of(a + (k / 3 - 1) * IMG_W + (k % 3 - 1));
        end
        return w;
    endfunction

`ifdef LBP_CODE_EN
    function automatic logic [7:0] exp_code(input logic [PW-1:0] p);
        logic [7:0] c;
        int nb[8] = '{0, 1, 2, 3, 5, 6, 7, 8};
        for (int j = 0; j < 8; j++) c[j] = (p[nb[j]*DW +: DW] >= p[4*DW +: DW]);
        return c;
    endfunction
`endif

    // Gray memory: data for a read appears the cycle after it is issued.
    always @(posedge clk) begin
        if (gray_req) gray_data <= pix_of(int'(gray_addr));
    end

    always @(negedge clk) begin
        if (mon_en && gray_req) begin
            if (exp_rd_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rd_unexpected: got addr %0d expected no read", gray_addr);
            end else begin
                check("rd_addr", 80'(gray_addr), 80'(exp_rd_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        logic [AW+PW-1:0] e;
        if (mon_en) begin
            if (chk_done) begin
                check("done_pulse", 80'(done), 80'(1));
                check("busy_after_last", 80'(busy), 80'(0));
                chk_done = 1'b0;
            end
            if (win_valid && win_ready) begin
                if (exp_win_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL win_unexpected: got addr %0d expected no window", win_addr);
                end else begin
                    e = exp_win_q.pop_front();
                    check("win_addr", 80'(win_addr), 80'(e[AW+PW-1:PW]));
                    check("win_pix", 80'(win_pix), 80'(e[PW-1:0]));
`ifdef LBP_CODE_EN
                    check("win_code", 80'(win_code), 80'(exp_code(e[PW-1:0])));
`endif
                end
                win_cnt++;
                if (int'(win_addr) == LAST_ADDR) chk_done = 1'b1;
            end
        end
    end

    task automatic wait_win(input int cyc0, input int limit, output int cyc);
        cyc = cyc0;
        while (cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (win_valid) break;
        end
    endtask

    initial begin
        int cyc;
        int n;
        reset      = 1'b1;
        start      = 1'b0;
        gray_ready = 1'b1;
        win_ready  = 1'b0;

        @(negedge clk);
        check("rst_gray_req", 80'(gray_req), 80'(0));
        check("rst_gray_addr", 80'(gray_addr), 80'(0));
        check("rst_win_valid", 80'(win_valid), 80'(0));
        check("rst_win_addr", 80'(win_addr), 80'(0));
        check("rst_win_pix", 80'(win_pix), 80'(0));
        check("rst_busy", 80'(busy), 80'(0));
        check("rst_done", 80'(done), 80'(0));
        @(posedge clk); #1 reset = 1'b0;

        // Scan abandoned by reset in the middle of FILL.
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("abort_req", 80'(gray_req), 80'(1));
        check("abort_addr", 80'(gray_addr), 80'(0));
        @(posedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("abort_req_low", 80'(gray_req), 80'(0));
        check("abort_valid_low", 80'(win_valid), 80'(0));
        check("abort_busy_low", 80'(busy), 80'(0));
        @(posedge clk); #1 reset = 1'b0;

        for (int r = 1; r <= IMG_H - 2; r++) begin
            for (int dx = -1; dx <= 1; dx++)
                for (int dy = -1; dy <= 1; dy++)
                    exp_rd_q.push_back(AW'((r + dy) * IMG_W + 1 + dx));
            for (int c = 2; c <= IMG_W - 2; c++)
                for (int dy = -1; dy <= 1; dy++)
                    exp_rd_q.push_back(AW'((r + dy) * IMG_W + c + 1));
            for (int c = 1; c <= IMG_W - 2; c++)
                exp_win_q.push_back({AW'(r * IMG_W + c), exp_window(r * IMG_W + c)});
        end
        mon_en = 1'b1;

        // First FILL with gray_ready pattern 1,0,0,1,...
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("fill_req_c1", 80'(gray_req), 80'(1));
        @(posedge clk); #1 gray_ready = 1'b0;
        @(negedge clk);
        check("fill_stall_c2", 80'(gray_req), 80'(0));
        check("fill_busy", 80'(busy), 80'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("fill_stall_c3", 80'(gray_req), 80'(0));
        @(posedge clk); #1 gray_ready = 1'b1;
        wait_win(3, 40, cyc);
        check("first_win_latency", 80'(cyc), 80'(13));

        for (int i = 0; i < 20; i++) begin
            check("hold_valid", 80'(win_valid), 80'(1));
            check("hold_addr", 80'(win_addr), 80'(IMG_W + 1));
            check("hold_pix", 80'(win_pix), 80'(exp_window(IMG_W + 1)));
            check("hold_no_prefetch", 80'(gray_req), 80'(0));
            @(negedge clk);
        end
        @(posedge clk); #1 win_ready = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("slide_req", 80'(gray_req), 80'(1));
        end
        @(negedge clk);
        check("slide_drain_req", 80'(gray_req), 80'(0));
        check("slide_drain_valid", 80'(win_valid), 80'(0));
        @(negedge clk);
        check("slide_valid", 80'(win_valid), 80'(1));
        check("slide_addr", 80'(win_addr), 80'(IMG_W + 2));

        n = 0;
        while (n < 2000 && !(win_valid && int'(win_addr) == 2 * IMG_W - 2)) begin
            @(negedge clk);
            n++;
        end
        check("wrap_src_addr", 80'(win_addr), 80'(2 * IMG_W - 2));
        @(negedge clk);
        for (int k = 1; k <= 9; k++) begin
            check("wrap_fill_req", 80'(gray_req), 80'(1));
            @(negedge clk);
        end
        check("wrap_drain_req", 80'(gray_req), 80'(0));
        check("wrap_drain_valid", 80'(win_valid), 80'(0));
        @(negedge clk);
        check("wrap_valid", 80'(win_valid), 80'(1));
        check("wrap_addr", 80'(win_addr), 80'(2 * IMG_W + 1));

        n = 0;
        while (n < 85000 && !done) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 80'(done), 80'(1));
        @(negedge clk);
        check("done_one_cycle", 80'(done), 80'(0));
        check("idle_busy", 80'(busy), 80'(0));
        check("win_count", 80'(win_cnt), 80'(NWIN));
        check("win_q_empty", 80'(exp_win_q.size()), 80'(0));
        check("rd_q_empty", 80'(exp_rd_q.size()), 80'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
